// File: rtl/bip_result_tx_sequencer.sv
// bip_result_tx_sequencer
//
// Counts clock cycles while the BIP core runs. On halt it snapshots the PC,
// the accumulator and the cycle count. It then streams a 9-byte result frame
// to a UART transmitter using a start/done byte handshake:
//   HEADER, pc[7:0], pc[15:8], acc[7:0], acc[15:8],
//   cnt[7:0], cnt[15:8], cnt[23:16], xor-checksum of the previous 8 bytes.
//
// Ports:
//   CLK         system clock, rising edge
//   RESET       asynchronous active-low reset
//   i_halt      BIP halt flag (level)
//   i_pc        BIP program counter (PC_W bits, zero-extended to 16)
//   i_acc       BIP accumulator (16 bits)
//   i_tx_done   one-cycle pulse from the UART when the current byte is out
//   o_tx_start  one-cycle pulse requesting transmission of o_tx_data
//   o_tx_data   registered byte to transmit
//   o_busy      high while a frame is in progress
//   o_done      sticky, high once the whole frame has been sent
module bip_result_tx_sequencer #(
  parameter int          PC_W   = 11,
  parameter int          CNT_W  = 24,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            i_halt,
  input  logic [PC_W-1:0] i_pc,
  input  logic [15:0]     i_acc,
  input  logic            i_tx_done,
  output logic            o_tx_start,
  output logic [7:0]      o_tx_data,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_snap_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [15:0]      acc_reg;
  logic [3:0]       idx_reg;
  logic             tx_start_reg;
  logic [7:0]       tx_data_reg;
  logic             busy_reg;
  logic             done_reg;

  // Zero-extended views of the snapshots in their frame widths.
  logic [15:0] pc16;
  logic [23:0] cnt24;

  always_comb begin
    pc16             = '0;
    pc16[PC_W-1:0]   = pc_reg;
    cnt24            = '0;
    cnt24[CNT_W-1:0] = cnt_snap_reg;
  end

  // Payload bytes 0..7; byte 8 is the running xor of these.
  logic [7:0] frame_body [0:7];

  always_comb begin
    frame_body[0] = HEADER;
    frame_body[1] = pc16[7:0];
    frame_body[2] = pc16[15:8];
    frame_body[3] = acc_reg[7:0];
    frame_body[4] = acc_reg[15:8];
    frame_body[5] = cnt24[7:0];
    frame_body[6] = cnt24[15:8];
    frame_body[7] = cnt24[23:16];
  end

  logic [7:0] xor_chain [0:7];

  assign xor_chain[0] = frame_body[0];

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ frame_body[gi];
    end
  endgenerate

  // Byte that will be loaded when advancing from WAIT to the next SEND.
  logic [3:0] idx_next;
  logic [7:0] next_byte;

  assign idx_next  = idx_reg + 4'd1;
  assign next_byte = (idx_next == 4'd8) ? xor_chain[7] : frame_body[idx_next[2:0]];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cnt_snap_reg <= '0;
      pc_reg       <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_halt) begin
            // The count is captured as-is; the halt edge itself is not counted.
            pc_reg       <= i_pc;
            acc_reg      <= i_acc;
            cnt_snap_reg <= cnt_reg;
            idx_reg      <= 4'd0;
            tx_data_reg  <= HEADER;
            tx_start_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= SEND;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SEND: begin
          tx_start_reg <= 1'b0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (idx_reg == 4'd8) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg      <= idx_next;
              tx_data_reg  <= next_byte;
              tx_start_reg <= 1'b1;
              state_reg    <= SEND;
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = tx_start_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_bip_result_tx_sequencer.sv
// Directed testbench for bip_result_tx_sequencer. A second instance with a
// 4-bit cycle counter exercises counter saturation.
module tb_bip_result_tx_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_halt;
  logic [10:0] i_pc;
  logic [15:0] i_acc;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  logic        s_halt;
  logic        s_tx_done;
  logic        s_tx_start;
  logic [7:0]  s_tx_data;
  logic        s_busy;
  logic        s_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_frame [9];

  always #5 CLK = ~CLK;

  bip_result_tx_sequencer #(.PC_W(11), .CNT_W(24), .HEADER(8'hA5)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_halt     (i_halt),
    .i_pc       (i_pc),
    .i_acc      (i_acc),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  bip_result_tx_sequencer #(.PC_W(11), .CNT_W(4), .HEADER(8'hA5)) dut_sat (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_halt     (s_halt),
    .i_pc       (i_pc),
    .i_acc      (i_acc),
    .i_tx_done  (s_tx_done),
    .o_tx_start (s_tx_start),
    .o_tx_data  (s_tx_data),
    .o_busy     (s_busy),
    .o_done     (s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives the main instance through a frame, acting as the UART (done 20
  // cycles after each start). Returns early in WAIT of byte abort_at.
  task automatic run_frame(input int abort_at, input bit disturb);
    logic [7:0] held;
    bit         stable;
    int         cyc;
    for (int b = 0; b < 9; b++) begin
      cyc = 0;
      while (o_tx_start !== 1'b1 && cyc < 50) begin
        step();
        cyc++;
      end
      chk($sformatf("start_seen_b%0d", b), o_tx_start, 1);
      chk($sformatf("byte_b%0d", b), o_tx_data, exp_frame[b]);
      chk($sformatf("busy_b%0d", b), o_busy, 1);
      held = o_tx_data;
      if (b == abort_at) begin
        step();
        return;
      end
      step();
      chk($sformatf("start_width_b%0d", b), o_tx_start, 0);
      stable = 1'b1;
      for (int c = 1; c < 19; c++) begin
        if (disturb) begin
          i_halt = c[0];
          i_pc   = 11'($urandom);
          i_acc  = 16'($urandom);
        end
        // Spurious done is not sent in WAIT; only check the data is held.
        step();
        if (o_tx_data !== held || o_tx_start !== 1'b0) stable = 1'b0;
      end
      chk($sformatf("wait_stable_b%0d", b), stable, 1);
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      if (b < 8) begin
        chk($sformatf("next_start_b%0d", b), o_tx_start, 1);
      end else begin
        chk("final_done", o_done, 1);
        chk("final_busy", o_busy, 0);
        chk("final_start", o_tx_start, 0);
      end
    end
  endtask

  initial begin
    int cyc;
    i_halt    = 1'($urandom);
    i_pc      = 11'($urandom);
    i_acc     = 16'($urandom);
    i_tx_done = 1'($urandom);
    s_halt    = 1'($urandom);
    s_tx_done = 1'($urandom);

    // Asynchronous reset, checked before any clock edge.
    #1 RESET = 1'b0;
    #1;
    chk("rst_start", o_tx_start, 0);
    chk("rst_data", o_tx_data, 8'h00);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sat_data", s_tx_data, 8'h00);

    i_halt    = 1'b0;
    i_tx_done = 1'b0;
    s_halt    = 1'b0;
    s_tx_done = 1'b0;
    step();
    step();
    RESET = 1'b1;

    // Nominal frame: 10 counting edges with spurious done pulses in IDLE.
    for (int i = 0; i < 10; i++) begin
      i_tx_done = (i == 3 || i == 6);
      step();
      i_tx_done = 1'b0;
      chk($sformatf("idle_nostart_%0d", i), o_tx_start, 0);
      chk($sformatf("idle_busy_%0d", i), o_busy, 0);
    end
    i_pc   = 11'h123;
    i_acc  = 16'hBEEF;
    i_halt = 1'b1;
    step();
    chk("halt_latency", o_tx_start, 1);
    exp_frame = '{8'hA5, 8'h23, 8'h01, 8'hEF, 8'hBE, 8'h0A, 8'h00, 8'h00, 8'hDC};
    run_frame(9, 1'b1);
    $display("nominal frame complete");

    // Spurious done and halt activity in DONE.
    for (int i = 0; i < 4; i++) begin
      i_tx_done = i[0];
      i_halt    = ~i_halt;
      step();
      chk($sformatf("done_hold_%0d", i), o_done, 1);
      chk($sformatf("done_nostart_%0d", i), o_tx_start, 0);
      chk($sformatf("done_busy_%0d", i), o_busy, 0);
      chk($sformatf("done_data_%0d", i), o_tx_data, 8'hDC);
    end
    i_tx_done = 1'b0;

    // Saturation on the 4-bit counter instance.
    RESET = 1'b0;
    step();
    i_halt = 1'b0;
    s_halt = 1'b0;
    i_pc   = 11'h000;
    i_acc  = 16'h0000;
    RESET  = 1'b1;
    repeat (20) step();
    s_halt = 1'b1;
    exp_frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'hAA};
    for (int b = 0; b < 9; b++) begin
      cyc = 0;
      while (s_tx_start !== 1'b1 && cyc < 50) begin
        step();
        cyc++;
      end
      chk($sformatf("sat_start_b%0d", b), s_tx_start, 1);
      chk($sformatf("sat_byte_b%0d", b), s_tx_data, exp_frame[b]);
      step();
      step();
      s_tx_done = 1'b1;
      step();
      s_tx_done = 1'b0;
    end
    chk("sat_done", s_done, 1);
    $display("saturation frame complete");

    // Reset in WAIT of byte 3, then a fresh frame.
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    repeat (3) step();
    i_pc   = 11'h7FF;
    i_acc  = 16'h1234;
    i_halt = 1'b1;
    step();
    exp_frame = '{8'hA5, 8'hFF, 8'h07, 8'h34, 8'h12, 8'h03, 8'h00, 8'h00, 8'h78};
    run_frame(3, 1'b0);
    RESET = 1'b0;
    #1;
    chk("midrst_start", o_tx_start, 0);
    chk("midrst_data", o_tx_data, 8'h00);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    #1;
    i_halt = 1'b0;
    i_pc   = 11'h000;
    i_acc  = 16'h0000;
    RESET  = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", o_busy, 0);
    i_halt = 1'b1;
    step();
    chk("post_rst_latency", o_tx_start, 1);
    exp_frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'hA0};
    run_frame(9, 1'b0);
    $display("post-reset frame complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
